// File: rtl/ps2_keyboard_mmio.sv
// PS/2 keyboard receiver: synchronizes the keyboard pins, decodes 11-bit frames,
// queues good bytes in a small FIFO and exposes them as a 32-bit polled I/O word.
module ps2_keyboard_mmio #(
  parameter int FIFO_AW        = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rd,
  output logic [31:0] io_rdata,
  output logic        ready,
  output logic        overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t state, state_next;

  logic          clk_s1, clk_s2, clk_prev;
  logic          data_s1, data_s2;
  logic          fall;
  logic [9:0]    shift_reg;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          frame_ok;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               pop, push_ok, drop;
  logic [7:0]         head_byte;

  // Pins idle high, so reset the synchronizers to 1 to avoid a phantom edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall    = clk_prev & ~clk_s2;
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (fall && !data_s2) state_next = SHIFT;
      end
      SHIFT: begin
        if (fall && bit_cnt == 4'd10) state_next = CHECK;
        else if (!fall && tmo_hit)    state_next = IDLE;
      end
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift register fills from the top so after ten samples it holds
  // {stop, parity, data[7:0]} with data bit 0 at position 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (fall && !data_s2) begin
            bit_cnt   <= 4'd1;
            shift_reg <= '0;
          end
        end
        SHIFT: begin
          if (fall) begin
            shift_reg <= {data_s2, shift_reg[9:1]};
            bit_cnt   <= bit_cnt + 4'd1;
            tmo_cnt   <= '0;
          end else if (tmo_hit) begin
            bit_cnt <= '0;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          bit_cnt <= '0;
          tmo_cnt <= '0;
        end
      endcase
    end
  end

  assign frame_ok = (state == CHECK) && shift_reg[9] && (^shift_reg[8:0]);

  // count only reaches DEPTH when full, so its top bit is the full flag.
  assign full    = count[FIFO_AW];
  assign ready   = (count != '0);
  assign pop     = rd && ready;
  assign push_ok = frame_ok && (!full || pop);
  assign drop    = frame_ok && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shift_reg[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as a read must still be reported.
      if (drop)    overflow <= 1'b1;
      else if (rd) overflow <= 1'b0;
    end
  end

  assign head_byte = ready ? mem[rd_ptr] : 8'h00;
  assign io_rdata  = {22'b0, overflow, ready, head_byte};

endmodule
